// File: rtl/bus_arbiter.sv
// Single-beat arbiter sharing one bus slave port among three masters:
// M0 = instruction fetch, M1 = load/store unit, M2 = CLINT/debug/DMA.
// Drives BusRequest/BusUsedEnd pulses for the pipeline controller and
// aborts a transaction with an error response if the slave never answers.
// Optional macro BUS_ARB_ROUND_ROBIN_EN selects round-robin arbitration;
// without it the arbiter uses fixed priority M1 > M2 > M0.
module bus_arbiter #(
    parameter int unsigned ADDR_W         = 64,
    parameter int unsigned DATA_W         = 64,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [2:0]              req_i,
    input  logic [3*ADDR_W-1:0]     addr_i,
    input  logic [2:0]              wen_i,
    input  logic [3*DATA_W-1:0]     wdata_i,
    input  logic [3*(DATA_W/8)-1:0] wstrb_i,
    output logic [2:0]              ack_o,
    output logic [DATA_W-1:0]       rdata_o,
    output logic                    err_o,
    output logic                    slv_valid_o,
    output logic [ADDR_W-1:0]       slv_addr_o,
    output logic                    slv_wen_o,
    output logic [DATA_W-1:0]       slv_wdata_o,
    output logic [DATA_W/8-1:0]     slv_wstrb_o,
    input  logic                    slv_ready_i,
    input  logic [DATA_W-1:0]       slv_rdata_i,
    output logic                    bus_request_o,
    output logic                    bus_used_end_o,
    output logic [1:0]              owner_o
);

    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned CNT_W  = 16;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StBusy = 2'd1;
    localparam logic [1:0] StResp = 2'd2;

    localparam logic [1:0] OwnerNone = 2'd3;

    // Last BUSY cycle index before the timeout fires
    localparam logic [CNT_W-1:0] CntLast = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]        state_q, state_d;
    logic [1:0]        owner_q, owner_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              bus_req_q, bus_req_d;
    logic [1:0]        winner;

`ifdef BUS_ARB_ROUND_ROBIN_EN
    logic [1:0] ptr_q, ptr_d;
    logic [1:0] cand1, cand2;

    function automatic logic [1:0] next_idx(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Search upward modulo 3 starting just after the last winner
    always_comb begin
        cand1 = next_idx(ptr_q);
        cand2 = next_idx(cand1);
        if (req_i[cand1]) begin
            winner = cand1;
        end else if (req_i[cand2]) begin
            winner = cand2;
        end else begin
            winner = ptr_q;
        end
    end

    // Pointer follows the most recent grant
    always_comb begin
        ptr_d = ptr_q;
        if (state_q == StIdle && req_i != 3'b000) begin
            ptr_d = winner;
        end
    end

    // Round-robin pointer register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= 2'd0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    // Fixed priority: load/store beats the DMA port, fetch goes last
    always_comb begin
        if (req_i[1]) begin
            winner = 2'd1;
        end else if (req_i[2]) begin
            winner = 2'd2;
        end else begin
            winner = 2'd0;
        end
    end
`endif

    // Next-state logic for the IDLE -> BUSY -> RESP transaction sequence
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        cnt_d     = cnt_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        bus_req_d = 1'b0;
        case (state_q)
            StIdle: begin
                if (req_i != 3'b000) begin
                    owner_d   = winner;
                    cnt_d     = '0;
                    state_d   = StBusy;
                    bus_req_d = (winner != 2'd0);
                end
            end
            StBusy: begin
                cnt_d = cnt_q + 1'b1;
                // A response in the timeout cycle still counts as a success
                if (slv_ready_i) begin
                    rdata_d = slv_rdata_i;
                    err_d   = 1'b0;
                    state_d = StResp;
                end else if (cnt_q == CntLast) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = StResp;
                end
            end
            StResp: begin
                cnt_d   = '0;
                owner_d = OwnerNone;
                state_d = StIdle;
            end
            default: begin
                cnt_d   = '0;
                owner_d = OwnerNone;
                state_d = StIdle;
            end
        endcase
    end

    // State registers; reset abandons any transaction in flight
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            owner_q   <= OwnerNone;
            cnt_q     <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            bus_req_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            cnt_q     <= cnt_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            bus_req_q <= bus_req_d;
        end
    end

    // Route the owner's request fields to the slave port
    always_comb begin
        slv_addr_o  = '0;
        slv_wen_o   = 1'b0;
        slv_wdata_o = '0;
        slv_wstrb_o = '0;
        case (owner_q)
            2'd0: begin
                slv_addr_o  = addr_i[0*ADDR_W +: ADDR_W];
                slv_wen_o   = wen_i[0];
                slv_wdata_o = wdata_i[0*DATA_W +: DATA_W];
                slv_wstrb_o = wstrb_i[0*STRB_W +: STRB_W];
            end
            2'd1: begin
                slv_addr_o  = addr_i[1*ADDR_W +: ADDR_W];
                slv_wen_o   = wen_i[1];
                slv_wdata_o = wdata_i[1*DATA_W +: DATA_W];
                slv_wstrb_o = wstrb_i[1*STRB_W +: STRB_W];
            end
            2'd2: begin
                slv_addr_o  = addr_i[2*ADDR_W +: ADDR_W];
                slv_wen_o   = wen_i[2];
                slv_wdata_o = wdata_i[2*DATA_W +: DATA_W];
                slv_wstrb_o = wstrb_i[2*STRB_W +: STRB_W];
            end
            default: ;
        endcase
    end

    // Status outputs decoded from the registered state
    always_comb begin
        slv_valid_o    = (state_q == StBusy);
        ack_o          = (state_q == StResp) ? (3'b001 << owner_q) : 3'b000;
        bus_used_end_o = (state_q == StResp) && (owner_q == 2'd1 || owner_q == 2'd2);
        bus_request_o  = bus_req_q;
        rdata_o        = rdata_q;
        err_o          = err_q;
        owner_o        = owner_q;
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter (timeout shortened to 4).
module tb_bus_arbiter;

    localparam int unsigned AW = 64;
    localparam int unsigned DW = 64;
    localparam int unsigned SW = DW / 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [2:0]      req;
    logic [3*AW-1:0] addr;
    logic [2:0]      wen;
    logic [3*DW-1:0] wdata;
    logic [3*SW-1:0] wstrb;
    logic [2:0]      ack;
    logic [DW-1:0]   rdata;
    logic            err;
    logic            slv_valid;
    logic [AW-1:0]   slv_addr;
    logic            slv_wen;
    logic [DW-1:0]   slv_wdata;
    logic [SW-1:0]   slv_wstrb;
    logic            slv_ready;
    logic [DW-1:0]   slv_rdata;
    logic            bus_request;
    logic            bus_used_end;
    logic [1:0]      owner;

    int n_checks = 0;
    int n_fail   = 0;

    bus_arbiter #(
        .ADDR_W         (AW),
        .DATA_W         (DW),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .req_i          (req),
        .addr_i         (addr),
        .wen_i          (wen),
        .wdata_i        (wdata),
        .wstrb_i        (wstrb),
        .ack_o          (ack),
        .rdata_o        (rdata),
        .err_o          (err),
        .slv_valid_o    (slv_valid),
        .slv_addr_o     (slv_addr),
        .slv_wen_o      (slv_wen),
        .slv_wdata_o    (slv_wdata),
        .slv_wstrb_o    (slv_wstrb),
        .slv_ready_i    (slv_ready),
        .slv_rdata_i    (slv_rdata),
        .bus_request_o  (bus_request),
        .bus_used_end_o (bus_used_end),
        .owner_o        (owner)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int          vcnt;
    logic [2:0]  ack_seen;
    logic [1:0]  exp_own [6];

    initial begin
        rst       = 1'b1;
        req       = 3'b000;
        addr      = '0;
        wen       = 3'b000;
        wdata     = '0;
        wstrb     = '0;
        slv_ready = 1'b0;
        slv_rdata = '0;
        step();
        step();
        check_eq("rst_owner", 64'(owner), 64'd3);
        check_eq("rst_ack", 64'(ack), 64'd0);
        check_eq("rst_valid", 64'(slv_valid), 64'd0);
        check_eq("rst_err", 64'(err), 64'd0);
        check_eq("rst_rdata", rdata, 64'd0);
        check_eq("rst_busreq", 64'(bus_request), 64'd0);
        check_eq("rst_busend", 64'(bus_used_end), 64'd0);
        rst = 1'b0;

        // M0 read, slave answers in the second BUSY cycle
        req = 3'b001;
        addr[0*AW +: AW] = 64'h8000_0000;
        step();
        check_eq("m0_valid", 64'(slv_valid), 64'd1);
        check_eq("m0_addr", slv_addr, 64'h8000_0000);
        check_eq("m0_owner", 64'(owner), 64'd0);
        check_eq("m0_busreq", 64'(bus_request), 64'd0);
        step();
        check_eq("m0_noack", 64'(ack), 64'd0);
        slv_ready = 1'b1;
        slv_rdata = 64'h1234;
        step();
        check_eq("m0_ack", 64'(ack), 64'b001);
        check_eq("m0_rdata", rdata, 64'h1234);
        check_eq("m0_err", 64'(err), 64'd0);
        check_eq("m0_busend", 64'(bus_used_end), 64'd0);
        check_eq("m0_valid_resp", 64'(slv_valid), 64'd0);
        req = 3'b000;
        slv_ready = 1'b0;
        step();
        check_eq("m0_idle_owner", 64'(owner), 64'd3);
        check_eq("m0_idle_ack", 64'(ack), 64'd0);
        check_eq("m0_rdata_hold", rdata, 64'h1234);

        // M0 and M1 together: M1 first, then M0 after one idle bubble
        req = 3'b011;
        addr[1*AW +: AW] = 64'h0000_2000;
        step();
        check_eq("m1_owner", 64'(owner), 64'd1);
        check_eq("m1_busreq", 64'(bus_request), 64'd1);
        check_eq("m1_addr", slv_addr, 64'h0000_2000);
        slv_ready = 1'b1;
        slv_rdata = 64'hAAAA;
        step();
        check_eq("m1_ack", 64'(ack), 64'b010);
        check_eq("m1_busend", 64'(bus_used_end), 64'd1);
        check_eq("m1_busreq_off", 64'(bus_request), 64'd0);
        req = 3'b001;
        slv_ready = 1'b0;
        step();
        check_eq("bubble_valid", 64'(slv_valid), 64'd0);
        step();
        check_eq("m0b_owner", 64'(owner), 64'd0);
        check_eq("m0b_busreq", 64'(bus_request), 64'd0);
        slv_ready = 1'b1;
        slv_rdata = 64'h5555;
        step();
        check_eq("m0b_ack", 64'(ack), 64'b001);
        check_eq("m0b_rdata", rdata, 64'h5555);
        check_eq("m0b_busend", 64'(bus_used_end), 64'd0);
        req = 3'b000;
        slv_ready = 1'b0;
        step();

        // M2 write: fields pass straight through to the slave
        req = 3'b100;
        wen = 3'b100;
        addr[2*AW +: AW] = 64'h0000_1000;
        wdata[2*DW +: DW] = 64'hDEAD_BEEF;
        wstrb[2*SW +: SW] = 8'h0F;
        step();
        check_eq("m2_owner", 64'(owner), 64'd2);
        check_eq("m2_busreq", 64'(bus_request), 64'd1);
        check_eq("m2_wen", 64'(slv_wen), 64'd1);
        check_eq("m2_wdata", slv_wdata, 64'hDEAD_BEEF);
        check_eq("m2_wstrb", 64'(slv_wstrb), 64'h0F);
        check_eq("m2_addr", slv_addr, 64'h0000_1000);
        step();
        check_eq("m2_busreq_pulse", 64'(bus_request), 64'd0);
        check_eq("m2_valid_wait", 64'(slv_valid), 64'd1);
        slv_ready = 1'b1;
        step();
        check_eq("m2_ack", 64'(ack), 64'b100);
        check_eq("m2_busend", 64'(bus_used_end), 64'd1);
        req = 3'b000;
        wen = 3'b000;
        slv_ready = 1'b0;
        step();

        // Dead slave: four BUSY cycles, then an error response
        req = 3'b001;
        vcnt = 0;
        ack_seen = 3'b000;
        for (int i = 0; i < 20; i++) begin
            step();
            if (ack != 3'b000) begin
                ack_seen = ack;
                break;
            end
            if (slv_valid) vcnt++;
        end
        check_eq("to_valid_cycles", 64'(vcnt), 64'd4);
        check_eq("to_ack", 64'(ack_seen), 64'b001);
        check_eq("to_err", 64'(err), 64'd1);
        check_eq("to_rdata", rdata, 64'd0);
        req = 3'b010;
        step();
        step();
        check_eq("post_to_owner", 64'(owner), 64'd1);
        slv_ready = 1'b1;
        slv_rdata = 64'h77;
        step();
        check_eq("post_to_ack", 64'(ack), 64'b010);
        check_eq("post_to_err", 64'(err), 64'd0);
        check_eq("post_to_rdata", rdata, 64'h77);
        req = 3'b000;
        slv_ready = 1'b0;
        step();

        // Reset in the second BUSY cycle abandons the transaction
        req = 3'b001;
        step();
        step();
        check_eq("mid_valid", 64'(slv_valid), 64'd1);
        rst = 1'b1;
        step();
        check_eq("mid_rst_valid", 64'(slv_valid), 64'd0);
        check_eq("mid_rst_ack", 64'(ack), 64'd0);
        check_eq("mid_rst_owner", 64'(owner), 64'd3);
        rst = 1'b0;
        req = 3'b000;
        slv_ready = 1'b1;
        ack_seen = 3'b000;
        for (int i = 0; i < 4; i++) begin
            step();
            ack_seen = ack_seen | ack;
        end
        check_eq("mid_no_late_ack", 64'(ack_seen), 64'd0);
        slv_ready = 1'b0;

        // All three requesting for six transactions
`ifdef BUS_ARB_ROUND_ROBIN_EN
        exp_own = '{2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd0};
`else
        exp_own = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1};
`endif
        req = 3'b111;
        for (int k = 0; k < 6; k++) begin
            step();
            check_eq($sformatf("grant%0d_owner", k), 64'(owner), 64'(exp_own[k]));
            slv_ready = 1'b1;
            step();
            check_eq($sformatf("grant%0d_ack", k), 64'(ack), 64'(3'b001 << exp_own[k]));
            slv_ready = 1'b0;
            step();
        end
        req = 3'b000;

`ifndef BUS_ARB_ROUND_ROBIN_EN
        // DMA port beats fetch under fixed priority
        req = 3'b101;
        step();
        check_eq("prio_m2_over_m0", 64'(owner), 64'd2);
        slv_ready = 1'b1;
        step();
        check_eq("prio_ack", 64'(ack), 64'b100);
        req = 3'b000;
        slv_ready = 1'b0;
        step();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
